// File: rtl/fsm_pkg.sv
// Shared types and constants for the A,B,B sequence detector.
// FSM_STATE_OUT_EN in the top adds a debug view of this state type.
package fsm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        GOT_A  = 2'd1,
        GOT_AB = 2'd2,
        MATCH  = 2'd3
    } state_t;

endpackage

// File: rtl/fsm.sv
// Moore detector that pulses Q for one cycle after sampling A, then B, then B.
// Defining FSM_STATE_OUT_EN adds the state_o debug port carrying the registered state.
module fsm
    import fsm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               A,
    input  logic               B,
    output logic               Q
`ifdef FSM_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0] state_o
`endif
);

    state_t r_state;
    state_t w_nextState;
    logic   r_q;

    // A always wins over B, so a fresh A restarts the pattern from any state.
    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE: begin
                if (A) w_nextState = GOT_A;
                else   w_nextState = IDLE;
            end
            GOT_A: begin
                if (A)      w_nextState = GOT_A;
                else if (B) w_nextState = GOT_AB;
                else        w_nextState = IDLE;
            end
            GOT_AB: begin
                if (A)      w_nextState = GOT_A;
                else if (B) w_nextState = MATCH;
                else        w_nextState = IDLE;
            end
            MATCH: begin
                if (A) w_nextState = GOT_A;
                else   w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Q is registered from the next state so it stays aligned with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_q     <= (w_nextState == MATCH);
        end
    end

    assign Q = r_q;

`ifdef FSM_STATE_OUT_EN
    assign state_o = r_state;
`endif

endmodule

// File: tb/tb_fsm.sv
// Directed-vector testbench for the A,B,B sequence detector.
// Checks Q always; also checks state_o when built with FSM_STATE_OUT_EN.
module tb_fsm;

    logic       clk;
    logic       reset;
    logic       A;
    logic       B;
    logic       Q;
`ifdef FSM_STATE_OUT_EN
    logic [1:0] stateO;
`endif

    int errors = 0;
    int checks = 0;

    fsm dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .Q       (Q)
`ifdef FSM_STATE_OUT_EN
        ,
        .state_o (stateO)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge that consumes them.
    task automatic applyStimulus(input string tag, input logic rst, input logic a, input logic b,
                                 input logic expQ, input logic [1:0] expState);
        reset = rst;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        checkOutput(tag, {1'b0, Q}, {1'b0, expQ});
`ifdef FSM_STATE_OUT_EN
        checkOutput({tag, "_state"}, stateO, expState);
`else
        if (expState > 2'd3) $display("[TB] unreachable state value");
`endif
    endtask

    initial begin
        reset = 1'b1;
        A     = 1'b0;
        B     = 1'b0;

        applyStimulus("reset",        1, 0, 0, 0, 2'd0);

        // Basic A,B,B then idle, including back-to-back B after MATCH
        applyStimulus("basic_a",      0, 1, 0, 0, 2'd1);
        applyStimulus("basic_b1",     0, 0, 1, 0, 2'd2);
        applyStimulus("basic_b2",     0, 0, 1, 1, 2'd3);
        applyStimulus("basic_b3",     0, 0, 1, 0, 2'd0);
        applyStimulus("basic_idle",   0, 0, 0, 0, 2'd0);

        // A,B then nothing falls back to IDLE
        applyStimulus("abort_a",      0, 1, 0, 0, 2'd1);
        applyStimulus("abort_b",      0, 0, 1, 0, 2'd2);
        applyStimulus("abort_none",   0, 0, 0, 0, 2'd0);

        // A held for three cycles, then B,B
        applyStimulus("hold_a1",      0, 1, 0, 0, 2'd1);
        applyStimulus("hold_a2",      0, 1, 0, 0, 2'd1);
        applyStimulus("hold_a3",      0, 1, 0, 0, 2'd1);
        applyStimulus("hold_b1",      0, 0, 1, 0, 2'd2);
        applyStimulus("hold_b2",      0, 0, 1, 1, 2'd3);
        applyStimulus("hold_end",     0, 0, 0, 0, 2'd0);

        // A and B together in GOT_AB: A priority restarts at GOT_A
        applyStimulus("prio_a",       0, 1, 0, 0, 2'd1);
        applyStimulus("prio_b",       0, 0, 1, 0, 2'd2);
        applyStimulus("prio_ab",      0, 1, 1, 0, 2'd1);
        applyStimulus("prio_b1",      0, 0, 1, 0, 2'd2);
        applyStimulus("prio_b2",      0, 0, 1, 1, 2'd3);
        applyStimulus("prio_a_match", 0, 1, 0, 0, 2'd1);
        applyStimulus("prio_end",     0, 0, 0, 0, 2'd0);

        // Reset in GOT_AB overrides a completing B
        applyStimulus("rstab_a",      0, 1, 0, 0, 2'd1);
        applyStimulus("rstab_b",      0, 0, 1, 0, 2'd2);
        applyStimulus("rstab_rst",    1, 0, 1, 0, 2'd0);
        applyStimulus("rstab_b1",     0, 0, 1, 0, 2'd0);
        applyStimulus("rstab_b2",     0, 0, 1, 0, 2'd0);
        applyStimulus("rstab_a2",     0, 1, 0, 0, 2'd1);
        applyStimulus("rstab_b3",     0, 0, 1, 0, 2'd2);
        applyStimulus("rstab_b4",     0, 0, 1, 1, 2'd3);

        // Reset while in MATCH, with A high, still lands in IDLE
        applyStimulus("rstm_rst",     1, 1, 0, 0, 2'd0);
        applyStimulus("rstm_b1",      0, 0, 1, 0, 2'd0);
        applyStimulus("rstm_b2",      0, 0, 1, 0, 2'd0);
        applyStimulus("rstm_a",       0, 1, 0, 0, 2'd1);
        applyStimulus("rstm_b3",      0, 0, 1, 0, 2'd2);
        applyStimulus("rstm_b4",      0, 0, 1, 1, 2'd3);
        applyStimulus("rstm_end",     0, 0, 0, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
